// File: rtl/tankbatt_rom_pkg.sv
// rtl/tankbatt_rom_pkg.sv - shared loader state encoding and ROM region map
package tankbatt_rom_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_RUN    = 2'd3
   } load_state_t;

   // Region base addresses within the downloaded image; each region ends
   // one byte below the next base, the last one ends at PROM_LIMIT.
   localparam logic [24:0] PRG0_BASE  = 25'h0000000;
   localparam logic [24:0] PRG1_BASE  = 25'h0000800;
   localparam logic [24:0] PRG2_BASE  = 25'h0001000;
   localparam logic [24:0] PRG3_BASE  = 25'h0001800;
   localparam logic [24:0] CHR_BASE   = 25'h0002000;
   localparam logic [24:0] PROM_BASE  = 25'h0002800;
   localparam logic [24:0] PROM_LIMIT = 25'h00028FF;

   // Bit positions within the one-hot region vector.
   localparam int RGN_PRG0  = 0;
   localparam int RGN_PRG1  = 1;
   localparam int RGN_PRG2  = 2;
   localparam int RGN_PRG3  = 3;
   localparam int RGN_CHR   = 4;
   localparam int RGN_PROM  = 5;
   localparam int RGN_COUNT = 6;

endpackage

// File: rtl/rom_region_decode.sv
// rtl/rom_region_decode.sv - maps a download byte address to its target ROM
module rom_region_decode
   import tankbatt_rom_pkg::*;
(
   input  logic [24:0]          addr,
   output logic [RGN_COUNT-1:0] region_oh,
   output logic                 out_of_range
);

   // Priority compare from the top of the map down; anything past the
   // colour PROM belongs to no ROM.
   always_comb begin
      region_oh    = '0;
      out_of_range = 1'b0;
      if (addr > PROM_LIMIT)
         out_of_range = 1'b1;
      else if (addr >= PROM_BASE)
         region_oh[RGN_PROM] = 1'b1;
      else if (addr >= CHR_BASE)
         region_oh[RGN_CHR] = 1'b1;
      else if (addr >= PRG3_BASE)
         region_oh[RGN_PRG3] = 1'b1;
      else if (addr >= PRG2_BASE)
         region_oh[RGN_PRG2] = 1'b1;
      else if (addr >= PRG1_BASE)
         region_oh[RGN_PRG1] = 1'b1;
      else
         region_oh[RGN_PRG0] = 1'b1;
   end

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - routes an ioctl ROM download into the game ROMs and holds cpu reset
module rom_loader #(
   parameter int          SETTLE_CYCLES = 16,
   parameter logic [7:0]  ROM_INDEX     = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [3:0]  prg_we,
   output logic        chr_we,
   output logic        prom_we,
   output logic [10:0] load_addr,
   output logic [7:0]  load_data,
   output logic        cpu_reset,
   output logic        rom_loaded,
   output logic        oversize,
   output logic [15:0] byte_count
);

   import tankbatt_rom_pkg::*;

   localparam logic [31:0] SETTLE_LAST =
      (SETTLE_CYCLES > 0) ? 32'(SETTLE_CYCLES - 1) : 32'd0;

   load_state_t          state, next_state;
   logic                 dl_match, dl_match_prev, dl_rise;
   logic                 write_accept, load_entry, settle_done;
   logic [31:0]          settle_cnt;
   logic [RGN_COUNT-1:0] region_oh;
   logic                 out_of_range;

   // Only sessions carrying our index count; others are invisible here.
   assign dl_match     = ioctl_download && (ioctl_index == ROM_INDEX);
   assign dl_rise      = dl_match && !dl_match_prev;
   assign write_accept = (state == ST_LOAD) && ioctl_wr && (ioctl_index == ROM_INDEX);
   assign load_entry   = (state != ST_LOAD) && (next_state == ST_LOAD);
   assign settle_done  = (settle_cnt >= SETTLE_LAST);

   rom_region_decode u_decode (
      .addr         (ioctl_addr),
      .region_oh    (region_oh),
      .out_of_range (out_of_range)
   );

   // State register plus the matching-download history used for edge detect.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         dl_match_prev <= 1'b0;
      end else begin
         state         <= next_state;
         dl_match_prev <= dl_match;
      end
   end

   // Next state and state-derived outputs; a new matching session restarts loading.
   always_comb begin
      next_state = state;
      cpu_reset  = 1'b1;
      rom_loaded = 1'b0;
      case (state)
         ST_IDLE:   if (dl_match) next_state = ST_LOAD;
         ST_LOAD:   if (!ioctl_download) next_state = ST_SETTLE;
         ST_SETTLE: begin
            if (dl_rise)          next_state = ST_LOAD;
            else if (settle_done) next_state = ST_RUN;
         end
         ST_RUN: begin
            cpu_reset  = 1'b0;
            rom_loaded = 1'b1;
            if (dl_rise) next_state = ST_LOAD;
         end
         default:   next_state = ST_IDLE;
      endcase
   end

   // Settle timer runs only while staying in SETTLE and restarts on every entry.
   always_ff @(posedge clk) begin
      if (reset || state != ST_SETTLE || next_state != ST_SETTLE)
         settle_cnt <= '0;
      else
         settle_cnt <= settle_cnt + 32'd1;
   end

   // Register each accepted byte and pulse its ROM enable for one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         prg_we     <= '0;
         chr_we     <= 1'b0;
         prom_we    <= 1'b0;
         load_addr  <= '0;
         load_data  <= '0;
         oversize   <= 1'b0;
         byte_count <= '0;
      end else begin
         prg_we  <= '0;
         chr_we  <= 1'b0;
         prom_we <= 1'b0;
         if (load_entry) begin
            oversize   <= 1'b0;
            byte_count <= '0;
         end
         if (write_accept) begin
            load_addr <= ioctl_addr[10:0];
            load_data <= ioctl_dout;
            if (out_of_range) begin
               oversize <= 1'b1;
            end else begin
               prg_we  <= region_oh[RGN_PRG3:RGN_PRG0];
               chr_we  <= region_oh[RGN_CHR];
               prom_we <= region_oh[RGN_PROM];
               if (byte_count != 16'hFFFF)
                  byte_count <= byte_count + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader
module tb_rom_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'h00;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic [3:0]  prg_we;
   logic        chr_we, prom_we;
   logic [10:0] load_addr;
   logic [7:0]  load_data;
   logic        cpu_reset, rom_loaded, oversize;
   logic [15:0] byte_count;

   typedef struct {
      logic [5:0]  en;
      logic [10:0] addr;
      logic [7:0]  data;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   region_cnt [6] = '{0, 0, 0, 0, 0, 0};

   rom_loader #(.SETTLE_CYCLES(16), .ROM_INDEX(8'h00)) dut (
      .clk            (clk),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .prg_we         (prg_we),
      .chr_we         (chr_we),
      .prom_we        (prom_we),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .cpu_reset      (cpu_reset),
      .rom_loaded     (rom_loaded),
      .oversize       (oversize),
      .byte_count     (byte_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, expv);
      end
   endtask

   function automatic logic [5:0] region_of(input int a);
      if (a < 'h2000)      return 6'(1 << (a / 'h800));
      else if (a < 'h2800) return 6'b010000;
      else if (a < 'h2900) return 6'b100000;
      else                 return 6'b000000;
   endfunction

   // Drive one strobe at the next falling edge; push the expected write if any.
   task automatic strobe(input int a, input logic [7:0] d, input logic [5:0] en_exp);
      exp_t e;
      @(negedge clk);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = d;
      if (en_exp != 6'b0) begin
         e.en   = en_exp;
         e.addr = 11'(a);
         e.data = d;
         e.due  = cyc + 1;
         exp_q.push_back(e);
      end
   endtask

   // Monitor: every enable pulse is matched against the oldest expected write.
   always @(negedge clk) begin
      logic [5:0] en;
      exp_t       e;
      en = {prom_we, chr_we, prg_we};
      if (!reset && cyc > 0) begin
         for (int k = 0; k < 6; k++) if (en[k] === 1'b1) region_cnt[k]++;
         if (en !== 6'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_enable: got en=%b addr=%h cyc=%0d want none", en, load_addr, cyc);
            end else begin
               e = exp_q.pop_front();
               if (en !== e.en || load_addr !== e.addr || load_data !== e.data || cyc != e.due) begin
                  n_err++;
                  $display("FAIL write: got en=%b addr=%h data=%h cyc=%0d want en=%b addr=%h data=%h cyc=%0d",
                           en, load_addr, load_data, cyc, e.en, e.addr, e.data, e.due);
               end
            end
         end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_write: got none want en=%b addr=%h cyc=%0d", e.en, e.addr, e.due);
         end
      end
   end

   initial begin
      int settle_n;
      bit loaded_early;

      repeat (3) @(negedge clk);
      check("rst_enables", {26'b0, prom_we, chr_we, prg_we}, 32'h0);
      check("rst_load_addr", 32'(load_addr), 32'h0);
      check("rst_load_data", 32'(load_data), 32'h0);
      check("rst_byte_count", 32'(byte_count), 32'h0);
      check("rst_oversize", 32'(oversize), 32'h0);
      check("rst_rom_loaded", 32'(rom_loaded), 32'h0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'h1);
      reset = 1'b0;

      // Full image, back-to-back strobes; the final strobe shares its cycle with download low.
      @(negedge clk);
      ioctl_download = 1'b1;
      ioctl_index    = 8'h00;
      for (int i = 0; i <= 'h28FF; i++) begin
         strobe(i, 8'(i), region_of(i));
         if (i == 'h28FF) ioctl_download = 1'b0;
      end
      @(negedge clk);
      ioctl_wr = 1'b0;
      settle_n = 0;
      loaded_early = 1'b0;
      while (cpu_reset === 1'b1 && settle_n < 64) begin
         settle_n++;
         if (rom_loaded !== 1'b0) loaded_early = 1'b1;
         @(negedge clk);
      end
      check("settle_cycles", 32'(settle_n), 32'd16);
      check("settle_no_early_loaded", 32'(loaded_early), 32'h0);
      check("run_cpu_reset", 32'(cpu_reset), 32'h0);
      check("run_rom_loaded", 32'(rom_loaded), 32'h1);
      check("full_byte_count", 32'(byte_count), 32'h2900);
      check("full_oversize", 32'(oversize), 32'h0);
      check("cnt_prg0", 32'(region_cnt[0]), 32'd2048);
      check("cnt_prg1", 32'(region_cnt[1]), 32'd2048);
      check("cnt_prg2", 32'(region_cnt[2]), 32'd2048);
      check("cnt_prg3", 32'(region_cnt[3]), 32'd2048);
      check("cnt_chr", 32'(region_cnt[4]), 32'd2048);
      check("cnt_prom", 32'(region_cnt[5]), 32'd256);

      // Foreign-index session in RUN must be invisible.
      @(negedge clk);
      ioctl_download = 1'b1;
      ioctl_index    = 8'h01;
      for (int i = 0; i < 4; i++) begin
         strobe('h10 + i, 8'h3C, 6'b0);
         @(negedge clk);
         ioctl_wr = 1'b0;
         check("foreign_no_enable", {26'b0, prom_we, chr_we, prg_we}, 32'h0);
         check("foreign_rom_loaded", 32'(rom_loaded), 32'h1);
      end
      @(negedge clk);
      ioctl_download = 1'b0;
      ioctl_index    = 8'h00;

      // Matching session from RUN reloads and clears status.
      @(negedge clk);
      ioctl_download = 1'b1;
      @(negedge clk);
      check("reload_rom_loaded", 32'(rom_loaded), 32'h0);
      check("reload_cpu_reset", 32'(cpu_reset), 32'h1);
      check("reload_byte_count", 32'(byte_count), 32'h0);

      // Region boundary on consecutive cycles.
      strobe('h07FF, 8'hA5, 6'b000001);
      strobe('h0800, 8'h5A, 6'b000010);
      @(negedge clk);
      ioctl_wr = 1'b0;
      @(negedge clk);
      check("boundary_byte_count", 32'(byte_count), 32'h2);

      // Just past the map, then the last PROM byte.
      strobe('h2900, 8'h77, 6'b0);
      @(negedge clk);
      ioctl_wr = 1'b0;
      check("over_no_enable", {26'b0, prom_we, chr_we, prg_we}, 32'h0);
      check("over_oversize", 32'(oversize), 32'h1);
      check("over_byte_count", 32'(byte_count), 32'h2);
      strobe('h28FF, 8'hC3, 6'b100000);
      @(negedge clk);
      ioctl_wr = 1'b0;
      @(negedge clk);
      check("prom_last_byte_count", 32'(byte_count), 32'h3);
      check("oversize_sticky", 32'(oversize), 32'h1);

      // Reset while a strobe is sampled: the pending enable is dropped.
      strobe('h0100, 8'h99, 6'b0);
      reset          = 1'b1;
      ioctl_download = 1'b0;
      @(negedge clk);
      reset    = 1'b0;
      ioctl_wr = 1'b0;
      check("midrst_no_enable", {26'b0, prom_we, chr_we, prg_we}, 32'h0);
      check("midrst_cpu_reset", 32'(cpu_reset), 32'h1);
      check("midrst_load_addr", 32'(load_addr), 32'h0);
      check("midrst_byte_count", 32'(byte_count), 32'h0);
      check("midrst_oversize", 32'(oversize), 32'h0);
      repeat (20) @(negedge clk);
      check("idle_holds_cpu_reset", 32'(cpu_reset), 32'h1);
      check("idle_rom_loaded", 32'(rom_loaded), 32'h0);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
